// File: rtl/prefetch_unit_if.sv
// prefetch_unit_if: redirect, instruction-memory and decode-side signals of the prefetch unit.
interface prefetch_unit_if #(
    parameter int PC_WIDTH = 9,
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4
);
    logic                       redirect_enable;
    logic [PC_WIDTH-1:0]        redirect_address;
    logic [PC_WIDTH-3:0]        imem_address;
    logic                       imem_read_enable;
    logic [XLEN-1:0]            imem_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_instruction;
    logic [PC_WIDTH-1:0]        out_pc;
    logic [$clog2(DEPTH):0]     occupancy;

    modport slave (
        input  redirect_enable, redirect_address, imem_data, out_ready,
        output imem_address, imem_read_enable, out_valid, out_instruction, out_pc, occupancy
    );

    modport master (
        output redirect_enable, redirect_address, imem_data, out_ready,
        input  imem_address, imem_read_enable, out_valid, out_instruction, out_pc, occupancy
    );
endinterface

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction prefetcher with a DEPTH-entry buffer over a 1-cycle-latency instruction memory.
module prefetch_unit #(
    parameter int PC_WIDTH = 9,
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    prefetch_unit_if.slave        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0] r_fetch_pc, r_inflight_pc, w_req_pc;
    logic                r_inflight, w_req, w_push, w_pop;
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [CW-1:0]       r_count;
    logic [XLEN-1:0]     r_instr [DEPTH];
    logic [PC_WIDTH-1:0] r_pc [DEPTH];

    // The in-flight request reserves a slot, so its push can never find the buffer full.
    always_comb begin
        w_req_pc = bus.redirect_enable ? (bus.redirect_address & ~PC_WIDTH'(3)) : r_fetch_pc;
        w_req    = !reset && (bus.redirect_enable ||
                   (({1'b0, r_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH)));
        w_push   = r_inflight && !bus.redirect_enable;
        w_pop    = (r_count != '0) && bus.out_ready && !bus.redirect_enable;
    end

    assign bus.imem_address     = w_req_pc[PC_WIDTH-1:2];
    assign bus.imem_read_enable = w_req;
    assign bus.occupancy        = r_count;
    assign bus.out_valid        = r_count != '0;
    assign bus.out_instruction  = bus.out_valid ? r_instr[r_rptr] : '0;
    assign bus.out_pc           = bus.out_valid ? r_pc[r_rptr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= PC_WIDTH'(RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= w_req_pc;
                r_fetch_pc    <= w_req_pc + PC_WIDTH'(4);
            end
            if (bus.redirect_enable) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                r_wptr  <= r_wptr + AW'(w_push);
                r_rptr  <= r_rptr + AW'(w_pop);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr[r_wptr] <= bus.imem_data;
            r_pc[r_wptr]    <= r_inflight_pc;
        end
    end
endmodule
